// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: three coins, per-item stock, refund, serial change.
// Define VEND_AUDIT_EN to add the saturating sales_cnt output.
module vend_ctrl_multi #(
  parameter int N_ITEMS    = 4,
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 5,
  parameter int COIN_A_VAL = 1,
  parameter int COIN_B_VAL = 2,
  parameter int COIN_C_VAL = 5,
  parameter int MAX_CREDIT = 15,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                reset_db,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                coin_c,
  input  logic                vend_req,
  input  logic [(N_ITEMS > 1 ? $clog2(N_ITEMS) : 1)-1:0] item_sel,
  input  logic                cancel,
  input  logic                restock,
  output logic [N_ITEMS-1:0]  dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]         sales_cnt
`endif
);

  localparam int CW1 = CREDIT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t state, nxt, step_nxt;

  logic [STOCK_W-1:0] stock [N_ITEMS];

  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic [CW1-1:0]      coin_val;
  logic [CW1-1:0]      coin_sum;
  logic                in_take;
  logic                coin_ok;
  logic                refund;
  logic                sel_ok;
  logic                vend_try;
  logic                vend_ok;
  logic                step;
  logic [CREDIT_W-1:0] credit_d;
  logic [N_ITEMS-1:0]  dispense_d;
  logic                pulse_d;
  logic                reject_d;
  logic                sold_d;
  logic                busy_d;

  // Decode coin and purchase conditions shared by both comb processes
  always_comb begin
    coin_cnt = {1'b0, coin_a} + {1'b0, coin_b} + {1'b0, coin_c};
    coin_any = coin_a | coin_b | coin_c;
    coin_val = '0;
    if (coin_a)      coin_val = CW1'(COIN_A_VAL);
    else if (coin_b) coin_val = CW1'(COIN_B_VAL);
    else if (coin_c) coin_val = CW1'(COIN_C_VAL);
    coin_sum = {1'b0, credit} + coin_val;
    in_take  = (state == S_IDLE) || (state == S_COLLECT);
    refund   = (state == S_COLLECT) && cancel;
    coin_ok  = in_take && (coin_cnt == 2'd1) && !refund &&
               (coin_sum <= CW1'(MAX_CREDIT));
    sel_ok   = int'(item_sel) < N_ITEMS;
    vend_try = (state == S_COLLECT) && vend_req && !cancel &&
               !coin_any && sel_ok;
    sold_d   = vend_try && (stock[item_sel] == '0);
    vend_ok  = vend_try && (stock[item_sel] != '0) &&
               (credit >= CREDIT_W'(PRICE));
    step     = (refund || (state == S_VEND) || (state == S_CHANGE)) &&
               (credit != '0);
    step_nxt = (credit > CREDIT_W'(1)) ? S_CHANGE : S_IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge reset_db) begin
    if (reset_db) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (coin_ok) nxt = S_COLLECT;
      S_COLLECT: begin
        if (refund)       nxt = step_nxt;
        else if (vend_ok) nxt = S_VEND;
      end
      S_VEND:    nxt = step_nxt;
      S_CHANGE:  nxt = step_nxt;
      default:   nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    credit_d = credit;
    if (coin_ok)      credit_d = coin_sum[CREDIT_W-1:0];
    else if (vend_ok) credit_d = credit - CREDIT_W'(PRICE);
    else if (step)    credit_d = credit - CREDIT_W'(1);
    dispense_d = vend_ok ? (N_ITEMS'(1) << item_sel) : '0;
    pulse_d    = step;
    reject_d   = coin_any && !coin_ok;
    busy_d     = (nxt == S_VEND) || (nxt == S_CHANGE) || step;
  end

  // Output registers; a strobe accepted at an edge shows up right after it
  always_ff @(posedge clk or posedge reset_db) begin
    if (reset_db) begin
      credit       <= '0;
      dispense     <= '0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      credit       <= credit_d;
      dispense     <= dispense_d;
      change_pulse <= pulse_d;
      coin_reject  <= reject_d;
      sold_out     <= sold_d;
      busy         <= busy_d;
    end
  end

  // Stock counters: reload on restock in IDLE, decrement on each sale
  always_ff @(posedge clk or posedge reset_db) begin
    if (reset_db) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if ((state == S_IDLE) && restock) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (vend_ok) begin
      stock[item_sel] <= stock[item_sel] - STOCK_W'(1);
    end
  end

`ifdef VEND_AUDIT_EN
  // Sales audit counter, saturating
  always_ff @(posedge clk or posedge reset_db) begin
    if (reset_db)
      sales_cnt <= '0;
    else if ((|dispense_d) && (sales_cnt != 16'hFFFF))
      sales_cnt <= sales_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi with default parameters.
// Stimulus queues expected strobe events; a negedge monitor pops and compares.
module tb_vend_ctrl_multi;

  logic       clk;
  logic       reset_db;
  logic       coin_a, coin_b, coin_c;
  logic       vend_req;
  logic [1:0] item_sel;
  logic       cancel, restock;
  logic [3:0] dispense;
  logic       change_pulse, coin_reject, sold_out, busy;
  logic [7:0] credit;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_cnt;
`endif

  vend_ctrl_multi dut (
    .clk          (clk),
    .reset_db     (reset_db),
    .coin_a       (coin_a),
    .coin_b       (coin_b),
    .coin_c       (coin_c),
    .vend_req     (vend_req),
    .item_sel     (item_sel),
    .cancel       (cancel),
    .restock      (restock),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .sold_out     (sold_out),
    .busy         (busy),
`ifdef VEND_AUDIT_EN
    .sales_cnt    (sales_cnt),
`endif
    .credit       (credit)
  );

  typedef struct {
    logic [3:0] disp;
    logic       cp;
    logic       rej;
    logic       so;
    logic       bsy;
    logic [7:0] cr;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ex(input logic [3:0] d, input logic cp, input logic rj,
                    input logic so, input logic b, input logic [7:0] cr);
    ev_t e;
    e.disp = d; e.cp = cp; e.rej = rj; e.so = so; e.bsy = b; e.cr = cr;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One clock of stimulus; inputs driven at negedge, held over one posedge
  task automatic tick(input logic a, input logic b, input logic c,
                      input logic v, input logic [1:0] s,
                      input logic cn, input logic rs);
    @(negedge clk);
    coin_a = a; coin_b = b; coin_c = c;
    vend_req = v; item_sel = s; cancel = cn; restock = rs;
    @(posedge clk);
    #1;
    coin_a = 0; coin_b = 0; coin_c = 0;
    vend_req = 0; item_sel = 0; cancel = 0; restock = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 2'd0, 0, 0);
  endtask

  // Monitor: every cycle presenting a strobe must match the next queued event
  always @(negedge clk) begin
    ev_t e;
    if (!reset_db &&
        ((|dispense) || change_pulse || coin_reject || sold_out)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: disp=%b cp=%b rej=%b so=%b cr=%0d",
                 dispense, change_pulse, coin_reject, sold_out, credit);
      end else begin
        e = q.pop_front();
        if ({e.disp, e.cp, e.rej, e.so, e.bsy, e.cr} !==
            {dispense, change_pulse, coin_reject, sold_out, busy, credit}) begin
          errors++;
          $display("FAIL event: got disp=%b cp=%b rej=%b so=%b busy=%b cr=%0d expected disp=%b cp=%b rej=%b so=%b busy=%b cr=%0d",
                   dispense, change_pulse, coin_reject, sold_out, busy, credit,
                   e.disp, e.cp, e.rej, e.so, e.bsy, e.cr);
        end
      end
    end
  end

  initial begin
    coin_a = 0; coin_b = 0; coin_c = 0;
    vend_req = 0; item_sel = 0; cancel = 0; restock = 0;
    reset_db = 1'b1;
    #13;
    chk("reset_credit", 32'(credit), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dispense", 32'(dispense), 32'd0);
    chk("reset_strobes", 32'({change_pulse, coin_reject, sold_out}), 32'd0);
    @(negedge clk);
    reset_db = 1'b0;

    // vend_req in IDLE is ignored
    tick(0, 0, 0, 1, 2'd3, 0, 0);

    // coin_b x3 then buy item 2: dispense, credit 1, one change pulse
    repeat (3) tick(0, 1, 0, 0, 2'd0, 0, 0);
    chk("credit_6", 32'(credit), 32'd6);
    ex(4'b0100, 0, 0, 0, 1, 8'd1);
    ex(4'b0000, 1, 0, 0, 1, 8'd0);
    tick(0, 0, 0, 1, 2'd2, 0, 0);
    chk("busy_vend", 32'(busy), 32'd1);
    idle(2);
    chk("after_vend_credit", 32'(credit), 32'd0);
    chk("after_vend_busy", 32'(busy), 32'd0);

    // credit 3 then cancel: three change pulses
    repeat (3) tick(1, 0, 0, 0, 2'd0, 0, 0);
    chk("credit_3", 32'(credit), 32'd3);
    ex(4'b0000, 1, 0, 0, 1, 8'd2);
    ex(4'b0000, 1, 0, 0, 1, 8'd1);
    ex(4'b0000, 1, 0, 0, 1, 8'd0);
    tick(0, 0, 0, 0, 2'd0, 1, 0);
    idle(2);
    chk("refund3_busy", 32'(busy), 32'd1);
    idle(1);
    chk("refund3_done", 32'({busy, change_pulse}), 32'd0);

    // credit 12; overflow coin and double coin both rejected
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    tick(0, 1, 0, 0, 2'd0, 0, 0);
    chk("credit_12", 32'(credit), 32'd12);
    ex(4'b0000, 0, 1, 0, 0, 8'd12);
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    ex(4'b0000, 0, 1, 0, 0, 8'd12);
    tick(1, 1, 0, 0, 2'd0, 0, 0);
    chk("credit_12_held", 32'(credit), 32'd12);

    // refund of 12 with a coin during CHANGE
    ex(4'b0000, 1, 0, 0, 1, 8'd11);
    tick(0, 0, 0, 0, 2'd0, 1, 0);
    ex(4'b0000, 1, 1, 0, 1, 8'd10);
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    for (int i = 9; i >= 0; i--) ex(4'b0000, 1, 0, 0, 1, 8'(i));
    idle(10);
    chk("refund12_credit", 32'(credit), 32'd0);

    // cancel together with a coin: coin rejected and credit refunded
    tick(1, 0, 0, 0, 2'd0, 0, 0);
    ex(4'b0000, 1, 1, 0, 1, 8'd0);
    tick(1, 0, 0, 0, 2'd0, 1, 0);
    idle(1);

    // insufficient credit: vend ignored, then refund 1
    tick(1, 0, 0, 0, 2'd0, 0, 0);
    tick(0, 0, 0, 1, 2'd1, 0, 0);
    chk("low_credit_held", 32'(credit), 32'd1);
    ex(4'b0000, 1, 0, 0, 1, 8'd0);
    tick(0, 0, 0, 0, 2'd0, 1, 0);
    idle(1);

    // item 0: eight sales succeed
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 1, 0, 2'd0, 0, 0);
      ex(4'b0001, 0, 0, 0, 1, 8'd0);
      tick(0, 0, 0, 1, 2'd0, 0, 0);
      idle(1);
    end
    // ninth: sold out, credit held; restock outside IDLE ignored
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    ex(4'b0000, 0, 0, 1, 0, 8'd5);
    tick(0, 0, 0, 1, 2'd0, 0, 0);
    chk("soldout_credit", 32'(credit), 32'd5);
    tick(0, 0, 0, 0, 2'd0, 0, 1);
    ex(4'b0000, 0, 0, 1, 0, 8'd5);
    tick(0, 0, 0, 1, 2'd0, 0, 0);
    for (int i = 4; i >= 0; i--) ex(4'b0000, 1, 0, 0, 1, 8'(i));
    tick(0, 0, 0, 0, 2'd0, 1, 0);
    idle(5);
    // restock in IDLE then item 0 sells again
    tick(0, 0, 0, 0, 2'd0, 0, 1);
    tick(0, 0, 1, 0, 2'd0, 0, 0);
    ex(4'b0001, 0, 0, 0, 1, 8'd0);
    tick(0, 0, 0, 1, 2'd0, 0, 0);
    idle(1);

    // reset during CHANGE with credit 4
    tick(0, 1, 0, 0, 2'd0, 0, 0);
    tick(0, 1, 0, 0, 2'd0, 0, 0);
    tick(0, 0, 0, 0, 2'd0, 1, 0);
    chk("change_started", 32'({change_pulse, credit}), 32'h103);
    #2;
    reset_db = 1'b1;
    #1;
    chk("midreset_pulse", 32'(change_pulse), 32'd0);
    chk("midreset_credit", 32'(credit), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_db = 1'b0;

    // three sales after reset
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0, 2'd0, 0, 0);
      ex(4'b0010, 0, 0, 0, 1, 8'd0);
      tick(0, 0, 0, 1, 2'd1, 0, 0);
      idle(1);
    end
`ifdef VEND_AUDIT_EN
    chk("sales_cnt", 32'(sales_cnt), 32'd3);
`endif
    chk("final_credit", 32'(credit), 32'd0);

    idle(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
